ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one 16x8 synchronous dual-port RAM (separate read/write ports, registered read data) between two clients, A and B.
- Per cycle it issues at most one write and at most one read.
- Write-port conflicts and read-port conflicts are each resolved by an independent round-robin pointer.
- A built-in clear sequencer zeroes all 16 locations on request; clients are blocked while it runs.

Parameters:
- RAM_WIDTH, 8, data width.
- RAM_DEPTH, 16, number of RAM words.
- ADDR_SIZE, 4, address width; RAM_DEPTH = 2**ADDR_SIZE.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high.
- req_a, req_b  input  1  client request, held until granted.
- we_a, we_b  input  1  1 = write, 0 = read.
- addr_a, addr_b  input  ADDR_SIZE  client address.
- wdata_a, wdata_b  input  RAM_WIDTH  client write data.
- gnt_a, gnt_b  output  1  combinational grant; the request is accepted at this clock edge.
- rvalid_a, rvalid_b  output  1  registered; read data valid for that client.
- rdata  output  RAM_WIDTH  passthrough of ram_data_out.
- clear_start  input  1  single-cycle pulse requesting a full clear.
- busy  output  1  high while in CLEAR.
- clear_done  output  1  registered one-cycle pulse at the end of a clear.
- ram_write, ram_read  output  1  RAM port enables.
- ram_write_addr, ram_read_addr  output  ADDR_SIZE  RAM addresses.
- ram_data_in  output  RAM_WIDTH  RAM write data.
- ram_data_out  input  RAM_WIDTH  RAM registered read data.

Behaviour:
- Reset is sampled on posedge clk:
  - state=IDLE; wr_ptr=A, rd_ptr=A; clr_addr=0.
  - rvalid_a/b=0, clear_done=0, busy=0.
  - gnt_a/b, ram_write and ram_read are forced to 0 combinationally while reset is high.
- FSM:
  - IDLE -> CLEAR on clear_start=1.
  - CLEAR -> IDLE after the write with clr_addr=RAM_DEPTH-1.
  - clear_start is ignored while in CLEAR.
  - Reset in CLEAR returns to IDLE with no clear_done pulse; memory is left partially cleared.
- IDLE write arbitration, among requests with we=1:
  - One requester: it is granted.
  - Both requesters: the client named by wr_ptr is granted, then wr_ptr moves to the loser.
  - wr_ptr does not change on uncontested grants.
- IDLE read arbitration (we=0) is identical, using rd_ptr and independent of the write arbitration.
- A write grant to one client and a read grant to the other may occur in the same cycle.
- On a write grant: ram_write=1, ram_write_addr and ram_data_in come from the granted client.
- On a read grant: ram_read=1, ram_read_addr comes from the granted client.
- Read latency: rvalid_x=1 on the cycle after gnt_x for a read, for exactly one cycle, with rdata=ram_data_out.
- Back-to-back reads are supported; one read completes per cycle.
- Read and write to the same address in the same cycle: the read returns the old value (the RAM's read-before-write behaviour).
- CLEAR:
  - gnt_a=gnt_b=0 and ram_read=0.
  - ram_write=1, ram_write_addr=clr_addr, ram_data_in=0; clr_addr increments each cycle.
  - 16 cycles total. clear_done pulses on the first IDLE cycle after CLEAR. busy=1 throughout CLEAR.
- clear_start in the same cycle as a client request in IDLE: the client request is granted that cycle, and CLEAR starts the next cycle.
- A read granted on the cycle before CLEAR still produces its rvalid during the first CLEAR cycle.
- A request that is not granted must stay asserted; the arbiter holds no request state.

Optional Feature:
- Macro ARB_STALL_STATS_EN.
- When defined:
  - Adds output stall_cnt [7:0], reset to 0.
  - Increments once per cycle in which req_a or req_b is high and that client's gnt is 0. If both clients stall, it still increments by 1.
  - Saturates at 255; it is not cleared by CLEAR.
- When undefined: the port and counter are absent, and the remaining behaviour is identical.

Test Plan:
- Reset, then A writes 0x5A@3 with B idle -> gnt_a=1 same cycle. A then reads @3 -> rvalid_a=1 the next cycle with rdata=0x5A.
- A and B both write (A:0x11@1, B:0x22@2) for two consecutive cycles -> cycle1 gnt_a, cycle2 gnt_b. A read-back of @1=0x11 and @2=0x22.
- A writes 0x77@4 while B reads @4 in the same cycle, with 0x00 previously stored -> both granted; B rdata=0x00, and a subsequent read gives 0x77.
- Fill all addresses with 0xFF, pulse clear_start -> busy high for 16 cycles, gnt low throughout, clear_done pulses once. Reads of addresses 0..15 return 0x00.
- Assert reset at clear cycle 5 -> busy=0 next cycle, no clear_done; @0..@4=0x00, @5..@15 keep 0xFF.
- With ARB_STALL_STATS_EN: both clients read continuously for 10 cycles -> stall_cnt=10. Hold it 300 cycles -> stall_cnt=255.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-client arbiter in front of a 16x8 dual-port RAM with round-robin write/read
// arbitration and a built-in clear sequencer. Optional stall counter: ARB_STALL_STATS_EN.
module ram_port_arbiter #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 16,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic                 we_a,
    input  logic                 we_b,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [RAM_WIDTH-1:0] wdata_a,
    input  logic [RAM_WIDTH-1:0] wdata_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic                 rvalid_a,
    output logic                 rvalid_b,
    output logic [RAM_WIDTH-1:0] rdata,
    input  logic                 clear_start,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [ADDR_SIZE-1:0] ram_write_addr,
    output logic [ADDR_SIZE-1:0] ram_read_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    input  logic [RAM_WIDTH-1:0] ram_data_out,
    output logic [0:0]           fsm_state
`ifdef ARB_STALL_STATS_EN
    ,
    output logic [7:0]           stall_cnt
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic       PTR_A    = 1'b0;
    localparam logic       PTR_B    = 1'b1;

    logic [0:0]           state;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [ADDR_SIZE-1:0] clr_addr;

    logic in_idle;
    logic wreq_a, wreq_b, rreq_a, rreq_b;
    logic gnt_wa, gnt_wb, gnt_ra, gnt_rb;
    logic clr_last;

    // Handshake: a client holds req (with we/addr/wdata stable) until gnt is high in
    // the same cycle; the transfer happens at that clock edge. rvalid follows a read
    // grant by exactly one cycle and is never back-pressured.
    assign in_idle  = (state == ST_IDLE) && !reset;
    assign wreq_a   = in_idle && req_a && we_a;
    assign wreq_b   = in_idle && req_b && we_b;
    assign rreq_a   = in_idle && req_a && !we_a;
    assign rreq_b   = in_idle && req_b && !we_b;

    assign gnt_wa   = wreq_a && (!wreq_b || wr_ptr == PTR_A);
    assign gnt_wb   = wreq_b && (!wreq_a || wr_ptr == PTR_B);
    assign gnt_ra   = rreq_a && (!rreq_b || rd_ptr == PTR_A);
    assign gnt_rb   = rreq_b && (!rreq_a || rd_ptr == PTR_B);

    assign gnt_a    = gnt_wa || gnt_ra;
    assign gnt_b    = gnt_wb || gnt_rb;

    assign clr_last = (clr_addr == ADDR_SIZE'(RAM_DEPTH - 1));
    assign busy     = (state == ST_CLEAR);
    assign rdata    = ram_data_out;
    assign fsm_state = state;

    always_comb begin
        ram_write      = 1'b0;
        ram_read       = 1'b0;
        ram_write_addr = '0;
        ram_read_addr  = '0;
        ram_data_in    = '0;
        if (!reset) begin
            if (state == ST_CLEAR) begin
                ram_write      = 1'b1;
                ram_write_addr = clr_addr;
            end else begin
                if (gnt_wa || gnt_wb) begin
                    ram_write      = 1'b1;
                    ram_write_addr = gnt_wb ? addr_b : addr_a;
                    ram_data_in    = gnt_wb ? wdata_b : wdata_a;
                end
                if (gnt_ra || gnt_rb) begin
                    ram_read      = 1'b1;
                    ram_read_addr = gnt_rb ? addr_b : addr_a;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= PTR_A;
            rd_ptr     <= PTR_A;
            clr_addr   <= '0;
            rvalid_a   <= 1'b0;
            rvalid_b   <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            rvalid_a   <= gnt_ra;
            rvalid_b   <= gnt_rb;
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Pointer hands priority to the loser only when there was a contest.
                    if (wreq_a && wreq_b) wr_ptr <= ~wr_ptr;
                    if (rreq_a && rreq_b) rd_ptr <= ~rd_ptr;
                    clr_addr <= '0;
                    if (clear_start) state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_SIZE'(1);
                    if (clr_last) begin
                        state      <= ST_IDLE;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_STALL_STATS_EN
    logic stall;
    assign stall = (req_a && !gnt_a) || (req_b && !gnt_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 8'd0;
        end else if (stall && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: behavioural RAM, per-client read-data
// scoreboard queues and a negedge monitor that pops them on rvalid.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b, we_a, we_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [7:0] rdata;
    logic       clear_start, busy, clear_done;
    logic       ram_write, ram_read;
    logic [3:0] ram_write_addr, ram_read_addr;
    logic [7:0] ram_data_in, ram_data_out;
    logic [0:0] fsm_state;
`ifdef ARB_STALL_STATS_EN
    logic [7:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    logic [7:0] mem[16];

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata(rdata), .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
        .ram_write(ram_write), .ram_read(ram_read),
        .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .fsm_state(fsm_state)
`ifdef ARB_STALL_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Clock / RAM model (registered read, read-before-write)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_read) ram_data_out <= mem[ram_read_addr];
        if (ram_write) mem[ram_write_addr] <= ram_data_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        req_a = r; we_a = w; addr_a = a; wdata_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        req_b = r; we_b = w; addr_b = a; wdata_b = d;
    endtask

    task automatic check_gnt(input string name, input logic ea, input logic eb);
        #1;
        check({name, "_gnt_a"}, 32'(gnt_a), 32'(ea));
        check({name, "_gnt_b"}, 32'(gnt_b), 32'(eb));
    endtask

    task automatic fill_a(input logic [7:0] d);
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b1, 4'(i), d);
            next_cycle();
        end
        set_a(1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic readback_a(input logic [7:0] lo, input logic [7:0] hi, input int split);
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b0, 4'(i), 8'h00);
            check_gnt("readback", 1'b1, 1'b0);
            exp_a_q.push_back((i < split) ? lo : hi);
            next_cycle();
        end
        set_a(1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rvalid_a) begin
            if (exp_a_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rdata_a_unexpected: got rvalid_a data 0x%0h expected no rvalid", rdata);
            end else begin
                check("rdata_a", 32'(rdata), 32'(exp_a_q.pop_front()));
            end
        end
        if (rvalid_b) begin
            if (exp_b_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rdata_b_unexpected: got rvalid_b data 0x%0h expected no rvalid", rdata);
            end else begin
                check("rdata_b", 32'(rdata), 32'(exp_b_q.pop_front()));
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        ram_data_out = 8'h00;
        reset = 1'b1;
        clear_start = 1'b0;
        set_a(1'b1, 1'b1, 4'd3, 8'h5A);
        set_b(1'b1, 1'b0, 4'd3, 8'h00);

        // Reset: grants and RAM enables forced low
        next_cycle();
        next_cycle();
        check_gnt("in_reset", 1'b0, 1'b0);
        check("in_reset_ram_write", 32'(ram_write), 32'd0);
        check("in_reset_ram_read", 32'(ram_read), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rvalid_a", 32'(rvalid_a), 32'd0);
        check("reset_clear_done", 32'(clear_done), 32'd0);
        set_b(1'b0, 1'b0, 4'd0, 8'h00);
        next_cycle();
        reset = 1'b0;

        // A writes 0x5A@3, then reads it back
        check_gnt("wr_a", 1'b1, 1'b0);
        check("wr_a_ram_write", 32'(ram_write), 32'd1);
        check("wr_a_addr", 32'(ram_write_addr), 32'd3);
        check("wr_a_data", 32'(ram_data_in), 32'h5A);
        next_cycle();
        set_a(1'b1, 1'b0, 4'd3, 8'h00);
        check_gnt("rd_a", 1'b1, 1'b0);
        check("rd_a_ram_read", 32'(ram_read), 32'd1);
        check("rd_a_addr", 32'(ram_read_addr), 32'd3);
        exp_a_q.push_back(8'h5A);
        next_cycle();
        set_a(1'b0, 1'b0, 4'd0, 8'h00);
        check("rvalid_a_latency", 32'(rvalid_a), 32'd1);
        next_cycle();
        check("rvalid_a_one_cycle", 32'(rvalid_a), 32'd0);

        // Contested writes: A first (wr_ptr=A), then B
        set_a(1'b1, 1'b1, 4'd1, 8'h11);
        set_b(1'b1, 1'b1, 4'd2, 8'h22);
        check_gnt("wr_both_c1", 1'b1, 1'b0);
        next_cycle();
        check_gnt("wr_both_c2", 1'b0, 1'b1);
        check("wr_both_c2_data", 32'(ram_data_in), 32'h22);
        next_cycle();
        // Contested reads: A first (rd_ptr=A), B holds and follows
        set_a(1'b1, 1'b0, 4'd1, 8'h00);
        set_b(1'b1, 1'b0, 4'd2, 8'h00);
        check_gnt("rd_both_c1", 1'b1, 1'b0);
        exp_a_q.push_back(8'h11);
        next_cycle();
        set_a(1'b0, 1'b0, 4'd0, 8'h00);
        check_gnt("rd_both_c2", 1'b0, 1'b1);
        exp_b_q.push_back(8'h22);
        next_cycle();
        set_b(1'b0, 1'b0, 4'd0, 8'h00);

        // Same-address read and write: read returns old value
        set_a(1'b1, 1'b1, 4'd4, 8'h00);
        next_cycle();
        set_a(1'b1, 1'b1, 4'd4, 8'h77);
        set_b(1'b1, 1'b0, 4'd4, 8'h00);
        check_gnt("rw_same", 1'b1, 1'b1);
        exp_b_q.push_back(8'h00);
        next_cycle();
        set_a(1'b0, 1'b0, 4'd0, 8'h00);
        check_gnt("rw_after", 1'b0, 1'b1);
        exp_b_q.push_back(8'h77);
        next_cycle();
        set_b(1'b0, 1'b0, 4'd0, 8'h00);

        // Full clear; read granted alongside clear_start, then held during CLEAR
        fill_a(8'hFF);
        set_a(1'b1, 1'b0, 4'd0, 8'h00);
        clear_start = 1'b1;
        check_gnt("clr_start_rd", 1'b1, 1'b0);
        exp_a_q.push_back(8'hFF);
        next_cycle();
        clear_start = 1'b0;
        set_a(1'b1, 1'b0, 4'd5, 8'h00);
        for (int i = 0; i < 16; i++) begin
            check_gnt("clr", 1'b0, 1'b0);
            check("clr_busy", 32'(busy), 32'd1);
            check("clr_ram_read", 32'(ram_read), 32'd0);
            check("clr_ram_write", 32'(ram_write), 32'd1);
            check("clr_addr", 32'(ram_write_addr), 32'(i));
            check("clr_data", 32'(ram_data_in), 32'd0);
            check("clr_done_early", 32'(clear_done), 32'd0);
            next_cycle();
        end
        check("clr_done_pulse", 32'(clear_done), 32'd1);
        check("clr_busy_end", 32'(busy), 32'd0);
        check_gnt("clr_held_rd", 1'b1, 1'b0);
        exp_a_q.push_back(8'h00);
        next_cycle();
        set_a(1'b0, 1'b0, 4'd0, 8'h00);
        check("clr_done_once", 32'(clear_done), 32'd0);
        readback_a(8'h00, 8'h00, 16);

        // Reset during clear cycle 5 aborts it without clear_done
        fill_a(8'hFF);
        clear_start = 1'b1;
        next_cycle();
        clear_start = 1'b0;
        repeat (5) next_cycle();
        check("abort_addr", 32'(ram_write_addr), 32'd5);
        reset = 1'b1;
        #1;
        check("abort_ram_write", 32'(ram_write), 32'd0);
        next_cycle();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", 32'(clear_done), 32'd0);
            next_cycle();
        end
        readback_a(8'h00, 8'hFF, 5);

        // Both clients read continuously: grants alternate A,B,A,...
        set_a(1'b1, 1'b0, 4'd0, 8'h00);
        set_b(1'b1, 1'b0, 4'd6, 8'h00);
        for (int i = 0; i < 10; i++) begin
            check_gnt("alt_rd", (i % 2) == 0, (i % 2) == 1);
            if ((i % 2) == 0) exp_a_q.push_back(8'h00);
            else exp_b_q.push_back(8'hFF);
            next_cycle();
        end
`ifdef ARB_STALL_STATS_EN
        check("stall_cnt_10", 32'(stall_cnt), 32'd10);
        for (int i = 0; i < 300; i++) begin
            if ((i % 2) == 0) exp_a_q.push_back(8'h00);
            else exp_b_q.push_back(8'hFF);
            next_cycle();
        end
        check("stall_cnt_sat", 32'(stall_cnt), 32'd255);
`endif
        set_a(1'b0, 1'b0, 4'd0, 8'h00);
        set_b(1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) next_cycle();
        check("pending_a", 32'(exp_a_q.size()), 32'd0);
        check("pending_b", 32'(exp_b_q.size()), 32'd0);

        // Report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
